// File: rtl/demux_stream_pkg.sv
// Shared helpers for the stream demultiplexer: select-width calculation and
// the all-ones source used to build saturation limits.
package demux_stream_pkg;

   // Width of a channel index; never narrower than one bit.
   function automatic int sel_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // Widest counter supported; saturation limits are sliced from this.
   localparam int unsigned SAT_MAX_W = 64;
   localparam logic [SAT_MAX_W-1:0] SAT_ONES = '1;

endpackage

// File: rtl/demux_slot.sv
// One-entry output register for a single channel. Accepts a load in the same
// cycle it is popped, so a continuously ready consumer sees full throughput.
module demux_slot
   import demux_stream_pkg::*;
#(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic [W-1:0] din,
   input  logic         out_ready,
   output logic         out_valid,
   output logic [W-1:0] out_data,
   output logic         space
);

   logic         vld_p1;
   logic [W-1:0] data_p1;

   // Slot can take a word when empty or when the current word leaves this edge.
   assign space     = ~vld_p1 | out_ready;
   assign out_valid = vld_p1;
   assign out_data  = data_p1;

   // ---- stage p1: slot register; data is held, not cleared, after a pop ----
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_p1  <= 1'b0;
         data_p1 <= '0;
      end else if (load) begin
         vld_p1  <= 1'b1;
         data_p1 <= din;
      end else if (vld_p1 && out_ready) begin
         vld_p1  <= 1'b0;
      end
   end

endmodule

// File: rtl/demux_stream_router.sv
// Registered 1-to-N stream demultiplexer with broadcast. Decodes the
// destination, gates the producer handshake on slot space and counts words
// discarded for an out-of-range channel index.
module demux_stream_router
   import demux_stream_pkg::*;
#(
   parameter  int W     = 8,
   parameter  int N     = 8,
   parameter  int CNT_W = 8,
   localparam int SELW  = sel_w(N)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [W-1:0]      in_data,
   input  logic [SELW-1:0]   in_sel,
   input  logic              in_bcast,
   output logic [N-1:0]      out_valid,
   input  logic [N-1:0]      out_ready,
   output logic [N*W-1:0]    out_data,
   output logic              err_sel,
   output logic [CNT_W-1:0]  drop_cnt
);

   localparam logic [SELW:0]     N_L     = (SELW+1)'(N);
   localparam logic [CNT_W-1:0]  CNT_MAX = SAT_ONES[CNT_W-1:0];

   // Counter increment that sticks at all-ones instead of wrapping.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
      return (c == CNT_MAX) ? c : c + 1'b1;
   endfunction

   logic [N-1:0]           space;
   logic [N-1:0]           load;
   logic [(1<<SELW)-1:0]   space_pad;
   logic                   sel_ok;
   logic                   accept;
   logic                   drop;

   // Extra zero bit makes the range test exact even when N is a power of 2.
   assign sel_ok = ({1'b0, in_sel} < N_L);

   // Pad the space vector to the full index range so in_sel always indexes in bounds.
   always_comb begin
      space_pad        = '0;
      space_pad[N-1:0] = space;
   end

   // Ready decode: broadcast needs every slot, unicast its own, bad index always drains.
   always_comb begin
      in_ready = 1'b1;
      if (in_bcast)
         in_ready = &space;
      else if (sel_ok)
         in_ready = space_pad[in_sel];
   end

   assign accept = in_valid & in_ready;
   assign drop   = accept & ~in_bcast & ~sel_ok;

   for (genvar i = 0; i < N; i++) begin : g_slot
      assign load[i] = accept & (in_bcast | (sel_ok & (in_sel == SELW'(i))));

      demux_slot #(.W(W)) u_slot (
         .clk       (clk),
         .rst_n     (rst_n),
         .load      (load[i]),
         .din       (in_data),
         .out_ready (out_ready[i]),
         .out_valid (out_valid[i]),
         .out_data  (out_data[i*W +: W]),
         .space     (space[i])
      );
   end

   // ---- stage p1: discard pulse and saturating drop counter ----
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_sel  <= 1'b0;
         drop_cnt <= '0;
      end else begin
         err_sel <= drop;
         if (drop)
            drop_cnt <= sat_inc(drop_cnt);
      end
   end

endmodule

// File: tb/tb_demux_stream_router.sv
// Directed and randomised checks for demux_stream_router: an N=8 instance for
// routing, backpressure and broadcast, an N=6 instance for out-of-range drops.
module tb_demux_stream_router;

   logic        clk = 1'b0;
   logic        rst_n;

   // N=8 instance
   logic        v8, rdy8, bc8;
   logic [2:0]  sel8;
   logic [7:0]  d8, vld8, ordy8, cnt8;
   logic [63:0] od8;
   logic        err8;

   // N=6 instance
   logic        v6, rdy6, bc6;
   logic [2:0]  sel6;
   logic [7:0]  d6, cnt6;
   logic [5:0]  vld6, ordy6;
   logic [47:0] od6;
   logic        err6;

   int total = 0;
   int pass  = 0;

   always #5 clk = ~clk;

   demux_stream_router #(.W(8), .N(8), .CNT_W(8)) u_dut8 (
      .clk(clk), .rst_n(rst_n), .in_valid(v8), .in_ready(rdy8), .in_data(d8),
      .in_sel(sel8), .in_bcast(bc8), .out_valid(vld8), .out_ready(ordy8),
      .out_data(od8), .err_sel(err8), .drop_cnt(cnt8));

   demux_stream_router #(.W(8), .N(6), .CNT_W(8)) u_dut6 (
      .clk(clk), .rst_n(rst_n), .in_valid(v6), .in_ready(rdy6), .in_data(d6),
      .in_sel(sel6), .in_bcast(bc6), .out_valid(vld6), .out_ready(ordy6),
      .out_data(od6), .err_sel(err6), .drop_cnt(cnt6));

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act === exp) pass++;
      else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
   endtask

   typedef struct {
      logic       v;
      logic [2:0] sel;
      logic       bc;
      logic [7:0] d;
      logic [7:0] ordy;
      logic       exp_rdy;
      logic [7:0] exp_vld;
      logic [2:0] ch;
      logic [7:0] exp_d;
   } vec_t;

   function automatic vec_t mk(input logic v, input logic [2:0] sel, input logic bc,
                               input logic [7:0] d, input logic [7:0] ordy,
                               input logic er, input logic [7:0] ev,
                               input logic [2:0] ch, input logic [7:0] ed);
      vec_t t;
      t.v = v; t.sel = sel; t.bc = bc; t.d = d; t.ordy = ordy;
      t.exp_rdy = er; t.exp_vld = ev; t.ch = ch; t.exp_d = ed;
      return t;
   endfunction

   task automatic apply8(input vec_t t, input int idx);
      @(negedge clk);
      v8 = t.v; sel8 = t.sel; bc8 = t.bc; d8 = t.d; ordy8 = t.ordy;
      #1 chk($sformatf("vec%0d_in_ready", idx), rdy8, t.exp_rdy);
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d_out_valid", idx), vld8, t.exp_vld);
      chk($sformatf("vec%0d_out_data", idx), od8[t.ch*8 +: 8], t.exp_d);
   endtask

   task automatic step6(input logic v, input logic [2:0] sel, input logic bc, input logic [7:0] d);
      @(negedge clk);
      v6 = v; sel6 = sel; bc6 = bc; d6 = d;
   endtask

   vec_t        tv[$];
   logic [7:0]  mv;
   logic [63:0] md, mask;
   logic [7:0]  sp;
   logic        erdy;

   initial begin
      rst_n = 1'b0;
      v8 = 0; sel8 = 0; bc8 = 0; d8 = 0; ordy8 = 0;
      v6 = 0; sel6 = 0; bc6 = 0; d6 = 0; ordy6 = 6'h3F;
      #12;
      chk("rst_vld8", vld8, 0);
      chk("rst_data8", od8, 0);
      chk("rst_cnt8", cnt8, 0);
      chk("rst_err8", err8, 0);
      chk("rst_vld6", vld6, 0);
      chk("rst_cnt6", cnt6, 0);
      @(negedge clk);
      rst_n = 1'b1;

      // unicast sweep, one word per cycle
      for (int i = 0; i < 8; i++)
         tv.push_back(mk(1, 3'(i), 0, 8'(8'hA0 + i), 8'hFF, 1, 8'(1 << i), 3'(i), 8'(8'hA0 + i)));
      tv.push_back(mk(0, 3'd0, 0, 8'h00, 8'hFF, 1, 8'h00, 3'd7, 8'hA7));
      // backpressure on channel 3, channel 4 unaffected
      tv.push_back(mk(1, 3'd3, 0, 8'h55, 8'hF7, 1, 8'h08, 3'd3, 8'h55));
      tv.push_back(mk(1, 3'd3, 0, 8'h66, 8'hF7, 0, 8'h08, 3'd3, 8'h55));
      tv.push_back(mk(1, 3'd4, 0, 8'h77, 8'hF7, 1, 8'h18, 3'd4, 8'h77));
      tv.push_back(mk(1, 3'd3, 0, 8'h66, 8'hFF, 1, 8'h08, 3'd3, 8'h66));
      tv.push_back(mk(0, 3'd3, 0, 8'h00, 8'hFF, 1, 8'h00, 3'd3, 8'h66));
      // broadcast blocked by stalled channel 6, then released
      tv.push_back(mk(1, 3'd6, 0, 8'h99, 8'hBF, 1, 8'h40, 3'd6, 8'h99));
      tv.push_back(mk(1, 3'd0, 1, 8'hC3, 8'hBF, 0, 8'h40, 3'd0, 8'hA0));
      tv.push_back(mk(1, 3'd0, 1, 8'hC3, 8'hFF, 1, 8'hFF, 3'd2, 8'hC3));
      tv.push_back(mk(1, 3'd7, 1, 8'h3C, 8'hFF, 1, 8'hFF, 3'd5, 8'h3C));
      tv.push_back(mk(0, 3'd1, 0, 8'h00, 8'h00, 0, 8'hFF, 3'd1, 8'h3C));
      tv.push_back(mk(1, 3'd1, 0, 8'h11, 8'hFD, 0, 8'h02, 3'd1, 8'h3C));
      tv.push_back(mk(0, 3'd0, 0, 8'h00, 8'hFF, 1, 8'h00, 3'd1, 8'h3C));
      foreach (tv[k]) apply8(tv[k], k);

      // out-of-range index on the 6-channel instance
      step6(1, 3'd7, 0, 8'h12);
      #1 chk("oor_in_ready", rdy6, 1);
      @(posedge clk); #1;
      chk("oor_err", err6, 1);
      chk("oor_cnt", cnt6, 1);
      chk("oor_vld", vld6, 0);
      step6(0, 3'd0, 0, 8'h00);
      @(posedge clk); #1;
      chk("oor_err_pulse_end", err6, 0);
      chk("oor_cnt_hold", cnt6, 1);
      step6(1, 3'd7, 1, 8'h44);
      @(posedge clk); #1;
      chk("bcast_sel7_vld", vld6, 6'h3F);
      chk("bcast_sel7_cnt", cnt6, 1);
      chk("bcast_sel7_data5", od6[47:40], 8'h44);
      step6(1, 3'd5, 0, 8'h5E);
      @(posedge clk); #1;
      chk("uni5_vld", vld6, 6'h20);
      chk("uni5_data", od6[47:40], 8'h5E);
      chk("uni5_err", err6, 0);
      step6(1, 3'd6, 0, 8'h13);
      #1 chk("sel_eq_n_ready", rdy6, 1);
      @(posedge clk); #1;
      chk("sel_eq_n_cnt", cnt6, 2);
      chk("sel_eq_n_vld", vld6, 0);
      step6(1, 3'd7, 0, 8'h12);
      repeat (300) @(posedge clk);
      #1;
      chk("sat_cnt", cnt6, 8'hFF);
      chk("sat_err", err6, 1);
      step6(0, 3'd0, 0, 8'h00);
      @(posedge clk); #1;
      chk("sat_cnt_hold", cnt6, 8'hFF);
      chk("sat_err_clear", err6, 0);

      // random traffic on the 8-channel instance against a slot model
      mv = '0; md = '0;
      for (int c = 0; c < 200; c++) begin
         @(negedge clk);
         v8    = ($urandom_range(0, 3) != 0);
         bc8   = ($urandom_range(0, 7) == 0);
         sel8  = 3'($urandom_range(0, 7));
         d8    = 8'($urandom);
         ordy8 = 8'($urandom | $urandom);
         sp    = ~mv | ordy8;
         erdy  = bc8 ? (&sp) : sp[sel8];
         #1 chk($sformatf("rnd%0d_in_ready", c), rdy8, erdy);
         @(posedge clk);
         for (int i = 0; i < 8; i++) begin
            if (v8 && erdy && (bc8 || sel8 == 3'(i))) begin
               mv[i] = 1'b1;
               md[i*8 +: 8] = d8;
            end else if (mv[i] && ordy8[i]) begin
               mv[i] = 1'b0;
            end
         end
         #1;
         mask = '0;
         for (int i = 0; i < 8; i++) if (mv[i]) mask[i*8 +: 8] = 8'hFF;
         chk($sformatf("rnd%0d_out_valid", c), vld8, mv);
         chk($sformatf("rnd%0d_out_data", c), od8 & mask, md & mask);
      end

      // drain, fill all slots, then reset asynchronously mid-cycle
      @(negedge clk);
      v8 = 0; bc8 = 0; ordy8 = 8'hFF;
      @(negedge clk);
      v8 = 1; bc8 = 1; d8 = 8'h5A; ordy8 = 8'h00;
      @(posedge clk); #1;
      chk("prerst_vld", vld8, 8'hFF);
      #2 rst_n = 1'b0;
      #1;
      chk("async_rst_vld8", vld8, 0);
      chk("async_rst_data8", od8, 0);
      chk("async_rst_cnt6", cnt6, 0);
      chk("async_rst_vld6", vld6, 0);
      @(negedge clk);
      rst_n = 1'b1;
      v8 = 1; bc8 = 0; sel8 = 3'd2; d8 = 8'hE2; ordy8 = 8'hFF;
      @(posedge clk); #1;
      chk("post_rst_vld", vld8, 8'h04);
      chk("post_rst_data", od8[23:16], 8'hE2);
      @(negedge clk);
      v8 = 0;

      $display("%0d/%0d checks passed", pass, total);
      $finish;
   end

endmodule
